// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the alu issue stage
package alu_pkg;
  typedef enum logic [3:0] {
    AND = 4'b0000,
    OR  = 4'b0001,
    ADD = 4'b0010,
    SLL = 4'b0011,
    XOR = 4'b0100,
    SRL = 4'b0101,
    SUB = 4'b0110,
    EQ  = 4'b1000,
    NE  = 4'b1001,
    SRA = 4'b1010,
    SLT = 4'b1100,
    GE  = 4'b1101
  } alu_op_e;
  typedef enum logic [1:0] {MEM, BRANCH, RTYPE, ITYPE} aluop_class_e;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam int FUNCT7_ALT = 5;
endpackage

// File: rtl/alu.sv
// alu: combinational datapath selected by a 4-bit Operation code
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] operation,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic [DATA_WIDTH-1:0]    alu_result
);
  logic [4:0] shamt;
  assign shamt = src_b[4:0];
  always_comb begin
    alu_result = '0;
    case (operation)
      AND:     alu_result = src_a & src_b;
      OR:      alu_result = src_a | src_b;
      ADD:     alu_result = src_a + src_b;
      SLL:     alu_result = src_a << shamt;
      XOR:     alu_result = src_a ^ src_b;
      SRL:     alu_result = src_a >> shamt;
      SUB:     alu_result = src_a - src_b;
      EQ:      alu_result = DATA_WIDTH'(src_a == src_b);
      NE:      alu_result = DATA_WIDTH'(src_a != src_b);
      SRA:     alu_result = $signed(src_a) >>> shamt;
      SLT:     alu_result = DATA_WIDTH'($signed(src_a) < $signed(src_b));
      GE:      alu_result = DATA_WIDTH'($signed(src_a) >= $signed(src_b));
      default: alu_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_decode.sv
// alu_decode: maps ALUOp/funct3/funct7 to the alu Operation code
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] operation,
  output logic       is_branch,
  output logic       illegal
);
  logic alt, unused_funct7;
  assign alt = funct7[FUNCT7_ALT];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  always_comb begin
    operation = ADD;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  operation = EQ;
          F3_BNE:  operation = NE;
          F3_BLT:  operation = SLT;
          F3_BGE:  operation = GE;
          default: illegal = 1'b1;
        endcase
      end
      RTYPE, ITYPE: begin
        case (funct3)
          F3_ADD:  operation = (alu_op == RTYPE && alt) ? SUB : ADD;
          F3_SLL:  operation = SLL;
          F3_SLT:  operation = SLT;
          F3_XOR:  operation = XOR;
          F3_SR:   operation = alt ? SRA : SRL;
          F3_OR:   operation = OR;
          F3_AND:  operation = AND;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage valid/ready wrapper that decodes requests and drives alu
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_branch_taken,
  output logic                  out_illegal
);
  logic [3:0] dec_op;
  logic dec_branch, dec_illegal;
  logic s1_valid, s1_branch, s1_illegal, s2_free;
  logic [OPCODE_LENGTH-1:0] s1_op;
  logic [DATA_WIDTH-1:0] s1_a, s1_b, alu_result;
  logic [TAG_WIDTH-1:0] s1_tag;
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  alu_decode u_decode (
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .operation(dec_op), .is_branch(dec_branch), .illegal(dec_illegal)
  );
  alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
    .operation(s1_op), .src_a(s1_a), .src_b(s1_b), .alu_result(alu_result)
  );
  // S1 reloads whenever it is empty or draining into S2 on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_op            <= '0;
      s1_a             <= '0;
      s1_b             <= '0;
      s1_tag           <= '0;
      s1_branch        <= 1'b0;
      s1_illegal       <= 1'b0;
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_tag          <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op      <= OPCODE_LENGTH'(dec_op);
          s1_a       <= src_a;
          s1_b       <= src_b;
          s1_tag     <= in_tag;
          s1_branch  <= dec_branch;
          s1_illegal <= dec_illegal;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result       <= s1_illegal ? '0 : alu_result;
          out_tag          <= s1_tag;
          out_branch_taken <= s1_branch && !s1_illegal && alu_result[0];
          out_illegal      <= s1_illegal;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed stimulus against a request-queue model of alu_issue
module tb_alu_issue;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        tk;
    logic        ill;
    int          e;
  } exp_t;

  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_branch_taken, out_illegal;
  logic [1:0] alu_op = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [31:0] src_a = 0, src_b = 0, out_result;
  logic [4:0] in_tag = 0, out_tag;
  int checks = 0, errors = 0, edges = 0;
  exp_t q[$];
  logic [4:0] got_tags[$];

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Instruction semantics straight from the ISA, independent of opcode encodings
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    exp_t r;
    r.res = 0; r.tag = t; r.tk = 0; r.ill = 0; r.e = 0;
    if (op == 0) r.res = a + b;
    else if (op == 1) begin
      case (f3)
        0: r.res = {31'b0, a == b};
        1: r.res = {31'b0, a != b};
        4: r.res = {31'b0, $signed(a) < $signed(b)};
        5: r.res = {31'b0, $signed(a) >= $signed(b)};
        default: r.ill = 1;
      endcase
      r.tk = r.res[0];
    end else begin
      case (f3)
        0: r.res = (op == 2 && f7[5]) ? a - b : a + b;
        1: r.res = a << b[4:0];
        2: r.res = {31'b0, $signed(a) < $signed(b)};
        4: r.res = a ^ b;
        5: r.res = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        6: r.res = a | b;
        7: r.res = a & b;
        default: r.ill = 1;
      endcase
    end
    return r;
  endfunction

  exp_t f;
  int n;
  logic vis;
  always @(negedge clk) begin
    if (rst_n) begin
      n = q.size();
      check("in_ready", in_ready, !(n == 2 && !out_ready));
      vis = n > 0 && q[0].e < edges;
      check("out_valid", out_valid, vis);
      if (vis && out_valid) begin
        check("out_result", out_result, q[0].res);
        check("out_tag", out_tag, q[0].tag);
        check("out_branch_taken", out_branch_taken, q[0].tk);
        check("out_illegal", out_illegal, q[0].ill);
        if (out_ready) begin
          got_tags.push_back(q[0].tag);
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        f = model(alu_op, funct3, funct7, src_a, src_b, in_tag);
        f.e = edges + 1;
        q.push_back(f);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check("in_ready timeout", 0, 1);
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    alu_op = op; funct3 = f3; funct7 = f7; src_a = a; src_b = b; in_tag = t; in_valid = 1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    drive(op, f3, f7, a, b, t);
    wait_ready();
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic expect_next(input string name, input logic [31:0] res, input logic tk,
                             input logic ill, input logic [4:0] t);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (i == 10) check({name, " timeout"}, 0, 1);
    end
    check({name, " result"}, out_result, res);
    check({name, " taken"}, out_branch_taken, tk);
    check({name, " illegal"}, out_illegal, ill);
    check({name, " tag"}, out_tag, t);
  endtask

  logic [1:0]  v_op[13] = '{0, 2, 2, 3, 2, 2, 3, 2, 3, 1, 1, 2, 2};
  logic [2:0]  v_f3[13] = '{2, 1, 2, 2, 4, 5, 0, 6, 7, 0, 1, 0, 0};
  logic [6:0]  v_f7[13] = '{0, 0, 0, 0, 0, 7'h20, 7'h20, 0, 0, 0, 0, 7'h5f, 7'h7f};
  logic [31:0] v_a[13]  = '{7, 1, -3, 5, 32'hff00ff00, 32'hf0000000, 5, 32'h0f00, 32'hff, 4, 4, 9, 9};
  logic [31:0] v_b[13]  = '{9, 31, 2, -1, 32'h0ff00ff0, 28, 3, 32'h00f0, 32'h3c, 4, 4, 4, 4};

  initial begin
    #1 rst_n = 0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_result", out_result, 0);
    check("reset out_tag", out_tag, 0);
    check("reset taken", out_branch_taken, 0);
    check("reset illegal", out_illegal, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1 out_ready = 1;

    send(2, 0, 7'h20, 10, 3, 5);
    @(negedge clk);
    check("sub latency", out_valid, 0);
    @(negedge clk);
    check("sub valid", out_valid, 1);
    check("sub result", out_result, 7);
    check("sub tag", out_tag, 5);
    check("sub illegal", out_illegal, 0);
    @(posedge clk); #1;

    send(3, 5, 7'h20, 32'h8000_0000, 4, 1);
    expect_next("srai", 32'hf800_0000, 0, 0, 1);
    @(posedge clk); #1;
    send(3, 5, 7'h00, 32'h8000_0000, 4, 2);
    expect_next("srli", 32'h0800_0000, 0, 0, 2);
    @(posedge clk); #1;
    send(1, 5, 0, -1, -1, 3);
    expect_next("bge", 1, 1, 0, 3);
    @(posedge clk); #1;
    send(1, 4, 0, 5, -2, 4);
    expect_next("blt", 0, 0, 0, 4);
    @(posedge clk); #1;
    send(2, 3, 0, 6, 7, 9);
    expect_next("ill sltu", 0, 0, 1, 9);
    @(posedge clk); #1;
    send(1, 2, 0, 3, 3, 10);
    expect_next("ill branch", 0, 0, 1, 10);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) send(v_op[i], v_f3[i], v_f7[i], v_a[i], v_b[i], 5'(11 + i));
    repeat (4) @(posedge clk);
    #1;

    got_tags.delete();
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 0, 100 + i, i, 5'(i));
      if (i == 1) out_ready = 0;
      for (int w = 0; w <= 40; w++) begin
        @(negedge clk);
        if (i == 2 && w == 0) check("in_ready drops", in_ready, 0);
        if (in_ready) break;
        if (w == 40) check("stall timeout", 0, 1);
        check("stall valid", out_valid, 1);
        check("stall tag", out_tag, 0);
        check("stall result", out_result, 100);
        if (w == 2) begin @(posedge clk); #1 out_ready = 1; end
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    check("b2b count", got_tags.size(), 4);
    for (int k = 0; k < 4 && k < got_tags.size(); k++) check("b2b order", got_tags[k], k);

    send(2, 0, 0, 1, 1, 20);
    send(2, 0, 0, 2, 2, 21);
    #1 rst_n = 0;
    q.delete();
    #1 check("midreset out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1 check("post reset in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no stale", out_valid, 0);
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
